psi_stream: RTL and testbench
=============================

PSI_STREAM -- requirements
Module: psi_stream

Interface
REQ-001 Parameter W, default 8: bit width of one set element, unsigned.
REQ-002 Parameter K, default 4: elements per party set, K >= 1, any integer (no power-of-2 restriction).
REQ-003 Parameter N, default 2: party count, N >= 2, any integer (no power-of-2 restriction).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  in_data holds a valid element.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 in_data  input  W  current party element; each party's K elements arrive strictly ascending.
REQ-009 out_valid  output  1  out_data holds a valid intersection element.
REQ-010 out_ready  input  1  sink accepts out_data this cycle.
REQ-011 out_data  output  W  intersection element; emitted ascending.
REQ-012 out_last  output  1  marks the final intersection element; qualified by out_valid.
REQ-013 done  output  1  one-cycle pulse at the end of each job.
REQ-014 count  output  CW  intersection size, CW = clog2(K+1); held stable from done until the next job's first accept.

Function
REQ-015 A transfer occurs on a clock edge where valid and ready are both high; nothing else advances either stream.
REQ-016 A job consumes N*K elements: party 0 first, then parties 1..N-1, each exactly K elements; parties are delimited only by element count.
REQ-017 FSM states: LOAD, MERGE, OUT, DONE; reset state LOAD.
REQ-018 LOAD: in_ready = 1; each transfer writes acc[ep] = in_data; on the K-th transfer cnt <= K, party <= 1, rp = wp = 0, go to MERGE.
REQ-019 MERGE (two-pointer, in place): a = acc[rp], d = in_data; if rp == cnt, in_ready = 1 and the element is discarded.
REQ-020 MERGE with rp < cnt: if a < d, in_ready = 0 and rp increments (accumulator skip, one entry per cycle).
REQ-021 MERGE with rp < cnt: if a == d, in_ready = 1; on transfer acc[wp] <= d, wp and rp increment.
REQ-022 MERGE with rp < cnt: if a > d, in_ready = 1; on transfer the element is discarded.
REQ-023 in_ready is combinational from state, rp, cnt, acc[rp] and in_data; it is 0 in OUT and DONE.
REQ-024 On the K-th transfer of a party in MERGE: cnt <= wp, including a match written that same cycle; rp, wp, ep reset to 0; party increments.
REQ-025 After party N-1 completes, go to OUT if the new cnt > 0, else go directly to DONE.
REQ-026 OUT: out_valid = 1, out_data = acc[op], out_last = (op == cnt-1); op increments per transfer; after the last transfer go to DONE.
REQ-027 out_valid, out_data and out_last are held stable while out_valid = 1 and out_ready = 0.
REQ-028 DONE: done = 1 and count = cnt for one cycle; then go to LOAD with party, ep and op cleared.
REQ-029 Worst-case cycles per job: N*K + (N-1)*K + cnt + 1, with no stalls from either stream.
REQ-030 A duplicate inside one party's set is outside the contract; the output is unspecified but the FSM still advances by element count.

Reset
REQ-031 While rst = 1, all registers clear asynchronously: state = LOAD; party, ep, rp, wp, op, cnt = 0; acc contents = 0.
REQ-032 While rst = 1, outputs are in_ready = 0, out_valid = 0, out_last = 0, done = 0, count = 0, out_data = 0.
REQ-033 Reset mid-job abandons the job; after rst falls, the next accepted element is party 0, element 0.

Structure
REQ-034 A shared package psi_pkg holds the clog2 function, the FSM state encoding and the CW derivation.
REQ-035 The accumulator is a K-entry register array inside psi_stream; no memory macro.
REQ-036 One sub-module, psi_cmp (W-bit unsigned lt/eq comparator), is instantiated once for the merge compare.

Verification
REQ-037 W=8, K=4, N=2; party0 {1,3,5,7}, party1 {3,4,5,9}, out_ready = 1 -> out 3, 5 (out_last on 5), count = 2, done pulses once.
REQ-038 N=3; {2,4,6,8}, {1,2,3,8}, {8,9,10,11} -> out 8 only, out_last = 1 on it, count = 1.
REQ-039 N=2; {1,2,3,4}, {5,6,7,8} -> no out_valid, OUT skipped, done with count = 0, in_ready = 0 during the 4-cycle acc skip.
REQ-040 Identical sets {10,20,30,40} for N=4, out_ready toggling 1/0 each cycle -> out 10, 20, 30, 40 held stable while stalled, count = 4.
REQ-041 Assert rst for 1 cycle after 6 elements of a job, then a full N=2 job {1,2,3,4}/{2,4,6,8} -> out 2, 4, count = 2; no residue from the aborted job.
REQ-042 K=3, N=5 (non-power-of-2), random ascending sets over 200 jobs -> out stream equals the reference set intersection, and cycle count <= the REQ-029 bound.

Source files
------------

// File: rtl/psi_pkg.sv
// Shared definitions for the private set intersection stream block:
// FSM state encoding and counter width derivation.
package psi_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        MERGE = 2'd1,
        OUT   = 2'd2,
        DONE  = 2'd3
    } psi_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Counters must hold the value K itself, so size for K+1 codes.
    function automatic int cnt_width(input int k);
        return (clog2(k + 1) < 1) ? 1 : clog2(k + 1);
    endfunction

endpackage

// File: rtl/psi_stream_if.sv
// Element stream in, intersection stream out, plus per-job done/count status.
// slave is the block side, master is the producer/consumer side.
interface psi_stream_if
    import psi_pkg::*;
#(
    parameter int W = 8,
    parameter int K = 4
);
    localparam int CW = cnt_width(K);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          done;
    logic [CW-1:0] count;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, done, count
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, done, count
    );

endinterface

// File: rtl/psi_cmp.sv
// Unsigned W-bit less-than / equal comparator for the merge step; purely combinational.
// No handshake: results follow the operands in the same cycle.
module psi_cmp #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt,
    output logic         eq
);

    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/psi_stream.sv
// N-party sorted set intersection: loads party 0, merges parties 1..N-1 in place, streams result.
// Latency N*K + skips + cnt + 1 cycles per job; in_ready drops during accumulator skips, out holds under out_ready=0.
module psi_stream
    import psi_pkg::*;
#(
    parameter int W = 8,
    parameter int K = 4,
    parameter int N = 2
) (
    input  logic        clk,
    input  logic        rst,
    psi_stream_if.slave bus
);

    localparam int CW = cnt_width(K);
    localparam int PW = cnt_width(N);

    localparam logic [CW-1:0] K_LAST = CW'(K - 1);
    localparam logic [CW-1:0] K_VAL  = CW'(K);
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [PW-1:0] P_LAST = PW'(N - 1);
    localparam logic [PW-1:0] P_ONE  = PW'(1);

    psi_state_t    state;
    psi_state_t    state_nx;

    logic [W-1:0]  acc [K];
    logic [CW-1:0] ep;
    logic [CW-1:0] rp;
    logic [CW-1:0] wp;
    logic [CW-1:0] op;
    logic [CW-1:0] cnt;
    logic [CW-1:0] count_q;
    logic [PW-1:0] party;

    logic [W-1:0]  a_sel;
    logic [W-1:0]  o_sel;
    logic          a_lt;
    logic          a_eq;
    logic          rp_end;
    logic          in_rdy;
    logic          skip;
    logic          match;
    logic          in_xfer;
    logic          out_vld;
    logic          out_lst;
    logic          out_xfer;
    logic          ep_last;
    logic          acc_we;
    logic [CW-1:0] acc_wi;
    logic [CW-1:0] cnt_merge_nx;

    // Mux-based reads keep the pointer widths independent of the array depth.
    always_comb begin
        a_sel = '0;
        o_sel = '0;
        for (int i = 0; i < K; i++) begin
            if (rp == CW'(i)) a_sel = acc[i];
            if (op == CW'(i)) o_sel = acc[i];
        end
    end

    psi_cmp #(.W(W)) u_cmp (
        .a  (a_sel),
        .b  (bus.in_data),
        .lt (a_lt),
        .eq (a_eq)
    );

    assign rp_end  = (rp == cnt);
    assign ep_last = (ep == K_LAST);

    always_comb begin
        in_rdy  = 1'b0;
        skip    = 1'b0;
        match   = 1'b0;
        out_vld = 1'b0;
        out_lst = 1'b0;
        case (state)
            LOAD: begin
                in_rdy = 1'b1;
            end
            MERGE: begin
                if (rp_end) begin
                    in_rdy = 1'b1;
                end else if (a_lt) begin
                    // Only skip against a real element; idle bus data is meaningless.
                    skip = bus.in_valid;
                end else begin
                    in_rdy = 1'b1;
                    match  = a_eq;
                end
            end
            OUT: begin
                out_vld = 1'b1;
                out_lst = (op == (cnt - ONE));
            end
            default: begin
            end
        endcase
    end

    assign in_xfer      = bus.in_valid & in_rdy;
    assign out_xfer     = out_vld & bus.out_ready;
    assign cnt_merge_nx = wp + CW'(match & in_xfer);
    assign acc_we       = in_xfer & ((state == LOAD) | ((state == MERGE) & match));
    assign acc_wi       = (state == LOAD) ? ep : wp;

    always_comb begin
        state_nx = state;
        case (state)
            LOAD: begin
                if (in_xfer && ep_last) state_nx = MERGE;
            end
            MERGE: begin
                if (in_xfer && ep_last && (party == P_LAST)) begin
                    state_nx = (cnt_merge_nx != '0) ? OUT : DONE;
                end
            end
            OUT: begin
                if (out_xfer && out_lst) state_nx = DONE;
            end
            DONE: begin
                state_nx = LOAD;
            end
            default: begin
                state_nx = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= LOAD;
            ep      <= '0;
            rp      <= '0;
            wp      <= '0;
            op      <= '0;
            cnt     <= '0;
            count_q <= '0;
            party   <= '0;
            for (int i = 0; i < K; i++) acc[i] <= '0;
        end else begin
            state <= state_nx;
            for (int i = 0; i < K; i++) begin
                if (acc_we && (acc_wi == CW'(i))) acc[i] <= bus.in_data;
            end
            case (state)
                LOAD: begin
                    if (in_xfer) begin
                        if (ep_last) begin
                            ep    <= '0;
                            cnt   <= K_VAL;
                            party <= P_ONE;
                            rp    <= '0;
                            wp    <= '0;
                        end else begin
                            ep <= ep + ONE;
                        end
                    end
                end
                MERGE: begin
                    if (skip) rp <= rp + ONE;
                    if (in_xfer) begin
                        if (match) begin
                            wp <= wp + ONE;
                            rp <= rp + ONE;
                        end
                        // End of party overrides the pointer bumps above.
                        if (ep_last) begin
                            cnt   <= cnt_merge_nx;
                            rp    <= '0;
                            wp    <= '0;
                            ep    <= '0;
                            party <= party + P_ONE;
                        end else begin
                            ep <= ep + ONE;
                        end
                    end
                end
                OUT: begin
                    if (out_xfer) op <= out_lst ? '0 : (op + ONE);
                end
                DONE: begin
                    count_q <= cnt;
                    party   <= '0;
                    ep      <= '0;
                    op      <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_rdy & ~rst;
    assign bus.out_valid = out_vld;
    assign bus.out_data  = out_vld ? o_sel : '0;
    assign bus.out_last  = out_vld & out_lst;
    assign bus.done      = (state == DONE);
    assign bus.count     = (state == DONE) ? cnt : count_q;

endmodule

// File: tb/tb_psi_stream.sv
// Scoreboard bench for psi_stream: four parameterisations share one driver, selected by sel.
module tb_psi_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       out_ready = 1'b1;
    logic       tog_en = 1'b0;
    int         sel = 0;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int skip_cyc = 0;
    int n_stall  = 0;

    logic [9:0] exp_q [$];
    logic [7:0] st [0:4][0:3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    psi_stream_if #(.W(8), .K(4)) if_a ();
    psi_stream_if #(.W(8), .K(4)) if_b ();
    psi_stream_if #(.W(8), .K(4)) if_c ();
    psi_stream_if #(.W(8), .K(3)) if_d ();

    assign if_a.in_valid  = in_valid && (sel == 0);
    assign if_b.in_valid  = in_valid && (sel == 1);
    assign if_c.in_valid  = in_valid && (sel == 2);
    assign if_d.in_valid  = in_valid && (sel == 3);
    assign if_a.in_data   = in_data;
    assign if_b.in_data   = in_data;
    assign if_c.in_data   = in_data;
    assign if_d.in_data   = in_data;
    assign if_a.out_ready = out_ready;
    assign if_b.out_ready = out_ready;
    assign if_c.out_ready = out_ready;
    assign if_d.out_ready = out_ready;

    psi_stream #(.W(8), .K(4), .N(2)) u_a (.clk(clk), .rst(rst), .bus(if_a));
    psi_stream #(.W(8), .K(4), .N(3)) u_b (.clk(clk), .rst(rst), .bus(if_b));
    psi_stream #(.W(8), .K(4), .N(4)) u_c (.clk(clk), .rst(rst), .bus(if_c));
    psi_stream #(.W(8), .K(3), .N(5)) u_d (.clk(clk), .rst(rst), .bus(if_d));

    logic       in_ready_m, out_valid_m, out_last_m, done_m;
    logic [7:0] out_data_m, count_m;

    always_comb begin
        case (sel)
            0: begin
                in_ready_m = if_a.in_ready; out_valid_m = if_a.out_valid; out_last_m = if_a.out_last;
                done_m = if_a.done; out_data_m = if_a.out_data; count_m = 8'(if_a.count);
            end
            1: begin
                in_ready_m = if_b.in_ready; out_valid_m = if_b.out_valid; out_last_m = if_b.out_last;
                done_m = if_b.done; out_data_m = if_b.out_data; count_m = 8'(if_b.count);
            end
            2: begin
                in_ready_m = if_c.in_ready; out_valid_m = if_c.out_valid; out_last_m = if_c.out_last;
                done_m = if_c.done; out_data_m = if_c.out_data; count_m = 8'(if_c.count);
            end
            default: begin
                in_ready_m = if_d.in_ready; out_valid_m = if_d.out_valid; out_last_m = if_d.out_last;
                done_m = if_d.done; out_data_m = if_d.out_data; count_m = 8'(if_d.count);
            end
        endcase
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: compares each accepted output and checks hold during stalls.
    logic       stall_prev = 1'b0;
    logic [8:0] held = 9'd0;
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", int'(out_valid_m), 1);
                chk("hold_data", int'({out_last_m, out_data_m}), int'(held));
            end
            if (out_valid_m && out_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'd0;
                chk("out_last_data", int'({1'b1, out_last_m, out_data_m}), int'(e));
            end
            stall_prev = out_valid_m && !out_ready;
            if (stall_prev) n_stall = n_stall + 1;
            held = {out_last_m, out_data_m};
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = tog_en ? ~out_ready : 1'b1;
        end
    end

    task automatic send(input logic [7:0] x);
        int  t;
        bit  got;
        in_valid = 1'b1;
        in_data  = x;
        t   = 0;
        got = 1'b0;
        while (!got && t < 100) begin
            @(negedge clk);
            if (in_ready_m) got = 1'b1;
            else begin
                t = t + 1;
                skip_cyc = skip_cyc + 1;
            end
        end
        if (!got) chk("in_ready_timeout", int'(got), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_job(input int s, input int n, input int k, input bit bound_chk);
        logic [7:0] hits [$];
        bit in_all, fnd, got;
        int cyc0, t, cycles;
        sel = s;
        for (int i = 0; i < k; i++) begin
            in_all = 1'b1;
            for (int p = 1; p < n; p++) begin
                fnd = 1'b0;
                for (int j = 0; j < k; j++) if (st[p][j] == st[0][i]) fnd = 1'b1;
                if (!fnd) in_all = 1'b0;
            end
            if (in_all) hits.push_back(st[0][i]);
        end
        for (int i = 0; i < hits.size(); i++)
            exp_q.push_back({1'b1, (i == hits.size() - 1), hits[i]});
        skip_cyc = 0;
        cyc0 = cyc;
        for (int p = 0; p < n; p++)
            for (int j = 0; j < k; j++) send(st[p][j]);
        got = 1'b0;
        t = 0;
        while (!got && t < 200) begin
            @(negedge clk);
            if (done_m) got = 1'b1;
            else t = t + 1;
        end
        chk("done_seen", int'(got), 1);
        if (got) begin
            chk("count", int'(count_m), hits.size());
            chk("out_drained", exp_q.size(), 0);
            if (bound_chk) begin
                cycles = cyc + 1 - cyc0;
                chk("cycle_bound", int'(cycles <= n * k + (n - 1) * k + hits.size() + 1), 1);
            end
        end
        exp_q.delete();
        @(negedge clk);
        chk("done_pulse", int'(done_m), 0);
        chk("count_hold", int'(count_m), hits.size());
        @(posedge clk);
        #1;
    endtask

    task automatic set_party(input int p, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
        st[p][0] = a; st[p][1] = b; st[p][2] = c; st[p][3] = d;
    endtask

    initial begin
        int v;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready_m), 0);
        chk("rst_out_valid", int'(out_valid_m), 0);
        chk("rst_out_last", int'(out_last_m), 0);
        chk("rst_done", int'(done_m), 0);
        chk("rst_count", int'(count_m), 0);
        chk("rst_out_data", int'(out_data_m), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        set_party(0, 1, 3, 5, 7);
        set_party(1, 3, 4, 5, 9);
        run_job(0, 2, 4, 1'b1);

        set_party(0, 2, 4, 6, 8);
        set_party(1, 1, 2, 3, 8);
        set_party(2, 8, 9, 10, 11);
        run_job(1, 3, 4, 1'b1);

        set_party(0, 1, 2, 3, 4);
        set_party(1, 5, 6, 7, 8);
        run_job(0, 2, 4, 1'b1);
        chk("skip_cycles", skip_cyc, 4);

        for (int p = 0; p < 4; p++) set_party(p, 10, 20, 30, 40);
        n_stall = 0;
        tog_en = 1'b1;
        run_job(2, 4, 4, 1'b0);
        tog_en = 1'b0;
        chk("stalls_seen", int'(n_stall > 0), 1);

        sel = 0;
        send(9); send(10); send(11); send(12); send(9); send(10);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", int'(in_ready_m), 0);
        chk("midrst_count", int'(count_m), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_party(0, 1, 2, 3, 4);
        set_party(1, 2, 4, 6, 8);
        run_job(0, 2, 4, 1'b1);

        for (int jb = 0; jb < 200; jb++) begin
            for (int p = 0; p < 5; p++) begin
                v = $urandom_range(0, 2);
                for (int j = 0; j < 3; j++) begin
                    st[p][j] = 8'(v);
                    v = v + 1 + $urandom_range(0, 1);
                end
            end
            run_job(3, 5, 3, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
